// File: rtl/fcache_call_ctrl.sv
// Call/return sequencer for the frame-cache backup path: turns held call/return
// requests into ordered single-cycle strobes to the backup stack and rms.
module fcache_call_ctrl #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned CNT_W = 5
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_call_req,
    input  logic             i_ret_req,
    input  logic             i_clr_err,
    output logic             o_ack,
    output logic             o_err,
    output logic             o_busy,
    output logic             o_fbs_backup,
    output logic             o_fbs_restore,
    output logic             o_rms_restore,
    output logic [CNT_W-1:0] o_depth,
    output logic             o_full,
    output logic             o_empty,
    output logic             o_ovf_sticky,
    output logic             o_unf_sticky,
    output logic             o_proto_sticky
);

    // One-hot so every strobe is a single register bit and cannot glitch.
    localparam int unsigned IDX_IDLE = 0;
    localparam int unsigned IDX_PUSH = 1;
    localparam int unsigned IDX_POP  = 2;
    localparam int unsigned IDX_LOAD = 3;
    localparam int unsigned IDX_ACK  = 4;

    localparam logic [4:0] S_IDLE = 5'b00001;
    localparam logic [4:0] S_PUSH = 5'b00010;
    localparam logic [4:0] S_POP  = 5'b00100;
    localparam logic [4:0] S_LOAD = 5'b01000;
    localparam logic [4:0] S_ACK  = 5'b10000;

    localparam logic [CNT_W-1:0] DEPTH_MAX = CNT_W'(DEPTH);

    logic [4:0]       r_state;
    logic [4:0]       w_state_d;
    logic [CNT_W-1:0] r_depth;
    logic [CNT_W-1:0] w_depth_d;
    logic             r_err_pend;
    logic             w_err_pend_d;
    logic             r_ovf;
    logic             r_unf;
    logic             r_proto;
    logic             w_ovf_set;
    logic             w_unf_set;
    logic             w_proto_set;
    logic             w_full;
    logic             w_empty;

    assign w_full  = (r_depth == DEPTH_MAX);
    assign w_empty = (r_depth == '0);

    always_comb begin
        w_state_d    = r_state;
        w_depth_d    = r_depth;
        w_err_pend_d = r_err_pend;
        w_ovf_set    = 1'b0;
        w_unf_set    = 1'b0;
        w_proto_set  = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_err_pend_d = 1'b0;
                if (i_call_req && i_ret_req) begin
                    w_state_d    = S_ACK;
                    w_err_pend_d = 1'b1;
                    w_proto_set  = 1'b1;
                end else if (i_call_req) begin
                    if (w_full) begin
                        w_state_d    = S_ACK;
                        w_err_pend_d = 1'b1;
                        w_ovf_set    = 1'b1;
                    end else begin
                        w_state_d = S_PUSH;
                    end
                end else if (i_ret_req) begin
                    if (w_empty) begin
                        w_state_d    = S_ACK;
                        w_err_pend_d = 1'b1;
                        w_unf_set    = 1'b1;
                    end else begin
                        w_state_d = S_POP;
                    end
                end
            end
            S_PUSH: begin
                w_depth_d = r_depth + CNT_W'(1);
                w_state_d = S_ACK;
            end
            S_POP: begin
                w_depth_d = r_depth - CNT_W'(1);
                w_state_d = S_LOAD;
            end
            S_LOAD:  w_state_d = S_ACK;
            S_ACK:   w_state_d = S_IDLE;
            default: w_state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state    <= S_IDLE;
            r_depth    <= '0;
            r_err_pend <= 1'b0;
            r_ovf      <= 1'b0;
            r_unf      <= 1'b0;
            r_proto    <= 1'b0;
        end else begin
            r_state    <= w_state_d;
            r_depth    <= w_depth_d;
            r_err_pend <= w_err_pend_d;
            // A set event wins over a simultaneous clear.
            r_ovf      <= w_ovf_set | (r_ovf & ~i_clr_err);
            r_unf      <= w_unf_set | (r_unf & ~i_clr_err);
            r_proto    <= w_proto_set | (r_proto & ~i_clr_err);
        end
    end

    assign o_fbs_backup   = r_state[IDX_PUSH];
    assign o_fbs_restore  = r_state[IDX_POP];
    assign o_rms_restore  = r_state[IDX_LOAD];
    assign o_ack          = r_state[IDX_ACK];
    assign o_err          = r_state[IDX_ACK] & r_err_pend;
    assign o_busy         = r_state[IDX_PUSH] | r_state[IDX_POP] | r_state[IDX_LOAD]
                          | (r_state[IDX_IDLE] & (i_call_req | i_ret_req));
    assign o_depth        = r_depth;
    assign o_full         = w_full;
    assign o_empty        = w_empty;
    assign o_ovf_sticky   = r_ovf;
    assign o_unf_sticky   = r_unf;
    assign o_proto_sticky = r_proto;

endmodule

// File: tb/tb_fcache_call_ctrl.sv
// Directed bench for fcache_call_ctrl: call/return sequencing, overflow,
// underflow, protocol errors, sticky clearing and reset in the middle of a return.
module tb_fcache_call_ctrl;

    logic       clk;
    logic       reset;
    logic       call_req;
    logic       ret_req;
    logic       clr_err;
    logic       ack;
    logic       err;
    logic       busy;
    logic       fbs_backup;
    logic       fbs_restore;
    logic       rms_restore;
    logic [4:0] depth;
    logic       full;
    logic       empty;
    logic       ovf_sticky;
    logic       unf_sticky;
    logic       proto_sticky;

    int n_chk  = 0;
    int n_pass = 0;

    fcache_call_ctrl #(
        .DEPTH (16),
        .CNT_W (5)
    ) dut (
        .i_clk          (clk),
        .i_reset        (reset),
        .i_call_req     (call_req),
        .i_ret_req      (ret_req),
        .i_clr_err      (clr_err),
        .o_ack          (ack),
        .o_err          (err),
        .o_busy         (busy),
        .o_fbs_backup   (fbs_backup),
        .o_fbs_restore  (fbs_restore),
        .o_rms_restore  (rms_restore),
        .o_depth        (depth),
        .o_full         (full),
        .o_empty        (empty),
        .o_ovf_sticky   (ovf_sticky),
        .o_unf_sticky   (unf_sticky),
        .o_proto_sticky (proto_sticky)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    // Advance one clock; inputs are driven and outputs sampled on the falling edge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic good_call(input int d0);
        call_req = 1'b1;
        #1;
        chk("call_c0_busy", busy, 1);
        chk("call_c0_backup", fbs_backup, 0);
        step();
        chk("call_c1_backup", fbs_backup, 1);
        chk("call_c1_ack", ack, 0);
        chk("call_c1_depth", depth, d0);
        step();
        chk("call_c2_ack", ack, 1);
        chk("call_c2_err", err, 0);
        chk("call_c2_backup", fbs_backup, 0);
        chk("call_c2_busy", busy, 0);
        chk("call_c2_depth", depth, d0 + 1);
        call_req = 1'b0;
        step();
        chk("call_c3_ack", ack, 0);
    endtask

    task automatic good_ret(input int d0);
        ret_req = 1'b1;
        #1;
        chk("ret_c0_busy", busy, 1);
        step();
        chk("ret_c1_pop", fbs_restore, 1);
        chk("ret_c1_load", rms_restore, 0);
        chk("ret_c1_depth", depth, d0);
        step();
        chk("ret_c2_pop", fbs_restore, 0);
        chk("ret_c2_load", rms_restore, 1);
        chk("ret_c2_ack", ack, 0);
        chk("ret_c2_depth", depth, d0 - 1);
        step();
        chk("ret_c3_ack", ack, 1);
        chk("ret_c3_err", err, 0);
        chk("ret_c3_load", rms_restore, 0);
        ret_req = 1'b0;
        step();
        chk("ret_c4_ack", ack, 0);
    endtask

    task automatic reject(input logic c, input logic r, input logic clr, input int d0);
        call_req = c;
        ret_req  = r;
        clr_err  = clr;
        #1;
        chk("rej_c0_busy", busy, 1);
        step();
        clr_err = 1'b0;
        chk("rej_c1_ack", ack, 1);
        chk("rej_c1_err", err, 1);
        chk("rej_c1_backup", fbs_backup, 0);
        chk("rej_c1_pop", fbs_restore, 0);
        chk("rej_c1_load", rms_restore, 0);
        chk("rej_c1_depth", depth, d0);
        call_req = 1'b0;
        ret_req  = 1'b0;
        step();
        chk("rej_c2_ack", ack, 0);
        chk("rej_c2_err", err, 0);
        chk("rej_c2_depth", depth, d0);
    endtask

    initial begin
        reset    = 1'b1;
        call_req = 1'b0;
        ret_req  = 1'b0;
        clr_err  = 1'b0;
        step();
        step();
        reset = 1'b0;
        for (int i = 0; i < 5; i++) step();
        chk("rst_depth", depth, 0);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ack", ack, 0);
        chk("rst_err", err, 0);
        chk("rst_strobes", {fbs_backup, fbs_restore, rms_restore}, 0);
        chk("rst_stickies", {ovf_sticky, unf_sticky, proto_sticky}, 0);

        // Single call then single return.
        good_call(0);
        chk("after_call_empty", empty, 0);
        good_ret(1);
        chk("after_ret_empty", empty, 1);

        // Fill the stack, then overflow.
        for (int i = 0; i < 16; i++) good_call(i);
        chk("fill_full", full, 1);
        chk("fill_depth", depth, 16);
        reject(1'b1, 1'b0, 1'b0, 16);
        chk("ovf_sticky_set", ovf_sticky, 1);
        chk("ovf_unf_clear", unf_sticky, 0);
        chk("ovf_proto_clear", proto_sticky, 0);
        chk("ovf_full_kept", full, 1);

        // Drain, then underflow and clear.
        for (int i = 16; i > 0; i--) good_ret(i);
        chk("drain_empty", empty, 1);
        reject(1'b0, 1'b1, 1'b0, 0);
        chk("unf_sticky_set", unf_sticky, 1);
        chk("unf_ovf_held", ovf_sticky, 1);
        clr_err = 1'b1;
        step();
        clr_err = 1'b0;
        chk("clr_unf", unf_sticky, 0);
        chk("clr_ovf", ovf_sticky, 0);

        // Both requests at depth 3, with clr_err in the same cycle as the set event.
        for (int i = 0; i < 3; i++) good_call(i);
        reject(1'b1, 1'b1, 1'b1, 3);
        chk("proto_sticky_set", proto_sticky, 1);
        chk("proto_ovf", ovf_sticky, 0);
        chk("proto_unf", unf_sticky, 0);

        // Reset during the POP cycle of a return at depth 4.
        good_call(3);
        ret_req = 1'b1;
        step();
        chk("mid_pop", fbs_restore, 1);
        chk("mid_pop_depth", depth, 4);
        reset = 1'b1;
        step();
        chk("mid_rst_depth", depth, 0);
        chk("mid_rst_ack", ack, 0);
        chk("mid_rst_load", rms_restore, 0);
        chk("mid_rst_pop", fbs_restore, 0);
        chk("mid_rst_proto", proto_sticky, 0);
        reset   = 1'b0;
        ret_req = 1'b0;
        #1;
        chk("mid_rst_busy", busy, 0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("post_rst_load", rms_restore, 0);
            chk("post_rst_ack", ack, 0);
            chk("post_rst_depth", depth, 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
